// File: rtl/ap_run_sequencer.sv
// Drives a kernel's ap_ctrl_hs handshake for a configured number of runs and
// counts the beats and packets the kernel emits while a sequence is active.
module ap_run_sequencer #(
  parameter int CNT_W = 16,
  parameter int TO_W  = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             go,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_runs,
  input  logic [TO_W-1:0]  cfg_timeout,
  output logic             dut_start,
  input  logic             dut_ready,
  input  logic             dut_done,
  input  logic             dut_idle,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  output logic             busy,
  output logic             seq_done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] runs_left,
  output logic [CNT_W-1:0] pkt_count,
  output logic [31:0]      beat_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e           state_q;
  logic             start_q;
  logic             busy_q;
  logic             seq_done_q;
  logic             terr_q;
  logic [CNT_W-1:0] runs_left_q;
  logic [TO_W-1:0]  timeout_q;
  logic [TO_W-1:0]  timer_q;
  logic [CNT_W-1:0] pkt_q;
  logic [31:0]      beat_q;

  logic             beat_fire;
  logic [CNT_W-1:0] pkt_d;
  logic [31:0]      beat_d;
  logic             timer_expired;

  // Both stream counters stick at all-ones instead of wrapping.
  assign beat_fire     = mon_tvalid & mon_tready;
  assign beat_d        = (&beat_q) ? beat_q : beat_q + 32'd1;
  assign pkt_d         = (&pkt_q) ? pkt_q : pkt_q + CNT_W'(1);
  assign timer_expired = (timeout_q != '0) && (timer_q == timeout_q - TO_W'(1));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      terr_q      <= 1'b0;
      runs_left_q <= '0;
      timeout_q   <= '0;
      timer_q     <= '0;
      pkt_q       <= '0;
      beat_q      <= 32'd0;
    end else begin
      seq_done_q <= 1'b0;

      if (busy_q && beat_fire) begin
        beat_q <= beat_d;
        if (mon_tlast) pkt_q <= pkt_d;
      end

      case (state_q)
        S_IDLE: begin
          if (go && dut_idle) begin
            if (cfg_runs == '0) begin
              seq_done_q <= 1'b1;
            end else begin
              state_q     <= S_START;
              start_q     <= 1'b1;
              busy_q      <= 1'b1;
              runs_left_q <= cfg_runs;
              timeout_q   <= cfg_timeout;
              pkt_q       <= '0;
              beat_q      <= 32'd0;
              terr_q      <= 1'b0;
            end
          end
        end

        S_START: begin
          if (abort) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (dut_ready) begin
            runs_left_q <= runs_left_q - CNT_W'(1);
            // A done seen with ready closes the run without visiting WAIT.
            if (dut_done) begin
              if (runs_left_q == CNT_W'(1)) begin
                state_q    <= S_IDLE;
                start_q    <= 1'b0;
                busy_q     <= 1'b0;
                seq_done_q <= 1'b1;
              end
            end else begin
              state_q <= S_WAIT;
              start_q <= 1'b0;
              timer_q <= '0;
            end
          end
        end

        S_WAIT: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (dut_done) begin
            if (runs_left_q == '0) begin
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              seq_done_q <= 1'b1;
            end else begin
              state_q <= S_START;
              start_q <= 1'b1;
            end
          end else if (timer_expired) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            terr_q     <= 1'b1;
            seq_done_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TO_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          start_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_start   = start_q;
  assign busy        = busy_q;
  assign seq_done    = seq_done_q;
  assign timeout_err = terr_q;
  assign runs_left   = runs_left_q;
  assign pkt_count   = pkt_q;
  assign beat_count  = beat_q;

endmodule

// File: tb/tb_ap_run_sequencer.sv
// Bench for ap_run_sequencer: vector table, directed corner cases, and a
// randomized run checked against a sequence-level reference model.
module tb_ap_run_sequencer;
  localparam int CNT_W = 4;
  localparam int TO_W  = 8;

  logic             ap_clk, ap_rst_n;
  logic             go, abort, dut_ready, dut_done, dut_idle;
  logic             mon_tvalid, mon_tready, mon_tlast;
  logic [CNT_W-1:0] cfg_runs;
  logic [TO_W-1:0]  cfg_timeout;
  logic             dut_start, busy, seq_done, timeout_err;
  logic [CNT_W-1:0] runs_left, pkt_count;
  logic [31:0]      beat_count;

  ap_run_sequencer #(.CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .go(go), .abort(abort),
    .cfg_runs(cfg_runs), .cfg_timeout(cfg_timeout), .dut_start(dut_start),
    .dut_ready(dut_ready), .dut_done(dut_done), .dut_idle(dut_idle),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .busy(busy), .seq_done(seq_done), .timeout_err(timeout_err),
    .runs_left(runs_left), .pkt_count(pkt_count), .beat_count(beat_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_starts = 0;
  int n_sd = 0;
  logic prev_start = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic tick();
    @(posedge ap_clk);
    #1;
    if (dut_start && !prev_start) n_starts++;
    prev_start = dut_start;
    if (seq_done) n_sd++;
  endtask

  task automatic clear_inputs();
    go = 0; abort = 0; cfg_runs = '0; cfg_timeout = '0;
    dut_ready = 0; dut_done = 0; dut_idle = 1;
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
  endtask

  task automatic start_seq(input int runs, input int tmo);
    go = 1; cfg_runs = CNT_W'(runs); cfg_timeout = TO_W'(tmo);
    tick();
    go = 0;
  endtask

  typedef struct packed {
    logic go, abort;
    logic [CNT_W-1:0] runs;
    logic ready, done, idle, tv, tr, tl;
    logic e_start, e_busy, e_sd;
    logic [CNT_W-1:0] e_rl, e_pkt;
    logic [31:0] e_beat;
  } vec_t;

  function automatic vec_t mkv(input int g, a, r, rdy, dn, idl, tv, tr, tl,
                               es, eb, esd, erl, epkt, ebeat);
    vec_t v;
    v.go = g[0]; v.abort = a[0]; v.runs = r[CNT_W-1:0];
    v.ready = rdy[0]; v.done = dn[0]; v.idle = idl[0];
    v.tv = tv[0]; v.tr = tr[0]; v.tl = tl[0];
    v.e_start = es[0]; v.e_busy = eb[0]; v.e_sd = esd[0];
    v.e_rl = erl[CNT_W-1:0]; v.e_pkt = epkt[CNT_W-1:0]; v.e_beat = ebeat;
    return v;
  endfunction

  // Reference model: tracks the sequence as runs issued out of a total,
  // with the timeout expressed as an absolute edge deadline.
  bit          m_active, m_req, m_terr, m_sd;
  int          m_total, m_issued, m_tmo, m_wait_edge, m_edge;
  logic [CNT_W-1:0] m_pkt;
  logic [31:0] m_beat;

  task automatic model_reset();
    m_active = 0; m_req = 0; m_terr = 0; m_sd = 0;
    m_total = 0; m_issued = 0; m_tmo = 0; m_wait_edge = 0; m_edge = 0;
    m_pkt = '0; m_beat = 32'd0;
  endtask

  task automatic model_step(input bit g, a, input int runs, tmo,
                            input bit rdy, dn, idl, tv, tr, tl);
    bit run_over;
    run_over = 0;
    m_edge++;
    m_sd = 0;
    if (m_active && tv && tr) begin
      if (m_beat != 32'hFFFF_FFFF) m_beat++;
      if (tl && m_pkt != {CNT_W{1'b1}}) m_pkt++;
    end
    if (!m_active) begin
      if (g && idl) begin
        if (runs == 0) m_sd = 1;
        else begin
          m_active = 1; m_req = 1; m_total = runs; m_issued = 0; m_tmo = tmo;
          m_pkt = '0; m_beat = 32'd0; m_terr = 0;
        end
      end
    end else if (a) begin
      m_active = 0;
    end else begin
      if (m_req) begin
        if (rdy) begin
          m_issued++;
          if (dn) run_over = 1;
          else begin m_req = 0; m_wait_edge = m_edge; end
        end
      end else if (dn) begin
        run_over = 1;
      end else if (m_tmo != 0 && (m_edge - m_wait_edge) == m_tmo) begin
        m_terr = 1; m_active = 0; m_sd = 1;
      end
      if (run_over) begin
        if (m_issued == m_total) begin m_active = 0; m_sd = 1; end
        else m_req = 1;
      end
    end
  endtask

  vec_t vecs[11];

  initial begin
    logic [CNT_W-1:0] rl_exp;
    bit g, a, rdy, dn, idl, tv, tr, tl;
    int runs, tmo;

    vecs[0]  = mkv(1,0,1, 0,0,1, 0,0,0,  1,1,0, 1,0,0);
    vecs[1]  = mkv(0,0,0, 1,1,1, 0,0,0,  0,0,1, 0,0,0);
    vecs[2]  = mkv(0,0,0, 0,0,1, 0,0,0,  0,0,0, 0,0,0);
    vecs[3]  = mkv(1,0,0, 0,0,1, 0,0,0,  0,0,1, 0,0,0);
    vecs[4]  = mkv(0,0,0, 0,0,1, 0,0,0,  0,0,0, 0,0,0);
    vecs[5]  = mkv(1,0,2, 0,0,0, 0,0,0,  0,0,0, 0,0,0);
    vecs[6]  = mkv(1,0,2, 0,0,1, 0,0,0,  1,1,0, 2,0,0);
    vecs[7]  = mkv(1,0,5, 1,0,1, 1,1,0,  0,1,0, 1,0,1);
    vecs[8]  = mkv(0,0,0, 0,1,1, 1,1,1,  1,1,0, 1,1,2);
    vecs[9]  = mkv(0,0,0, 1,1,1, 1,0,0,  0,0,1, 0,1,2);
    vecs[10] = mkv(0,0,0, 0,0,1, 1,1,1,  0,0,0, 0,1,2);

    clear_inputs();
    ap_rst_n = 0;
    #12;
    chk("reset_outputs", {dut_start, busy, seq_done, timeout_err, runs_left, pkt_count, beat_count},
        64'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1;

    // Vector table; vector 0 is the first go after reset release.
    for (int i = 0; i < 11; i++) begin
      go = vecs[i].go; abort = vecs[i].abort; cfg_runs = vecs[i].runs; cfg_timeout = '0;
      dut_ready = vecs[i].ready; dut_done = vecs[i].done; dut_idle = vecs[i].idle;
      mon_tvalid = vecs[i].tv; mon_tready = vecs[i].tr; mon_tlast = vecs[i].tl;
      tick();
      chk($sformatf("vec%0d_start", i), 64'(dut_start), 64'(vecs[i].e_start));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      chk($sformatf("vec%0d_seq_done", i), 64'(seq_done), 64'(vecs[i].e_sd));
      chk($sformatf("vec%0d_runs_left", i), 64'(runs_left), 64'(vecs[i].e_rl));
      chk($sformatf("vec%0d_pkt", i), 64'(pkt_count), 64'(vecs[i].e_pkt));
      chk($sformatf("vec%0d_beat", i), 64'(beat_count), 64'(vecs[i].e_beat));
    end
    clear_inputs();
    tick();

    // Normal run: 3 runs, 4 beats each with tlast on the 4th.
    n_starts = 0; n_sd = 0;
    start_seq(3, 0);
    for (int r = 0; r < 3; r++) begin
      chk($sformatf("normal_run%0d_start", r), 64'(dut_start), 64'd1);
      dut_ready = 1; tick(); dut_ready = 0;
      chk($sformatf("normal_run%0d_start_drop", r), 64'(dut_start), 64'd0);
      for (int c = 1; c <= 9; c++) begin
        mon_tvalid = (c <= 4); mon_tready = (c <= 4); mon_tlast = (c == 4);
        tick();
      end
      mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
      dut_done = 1; tick(); dut_done = 0;
    end
    tick();
    chk("normal_starts", 64'(n_starts), 64'd3);
    chk("normal_seq_done_pulses", 64'(n_sd), 64'd1);
    chk("normal_pkt", 64'(pkt_count), 64'd3);
    chk("normal_beat", 64'(beat_count), 64'd12);
    chk("normal_terr_busy_rl", {timeout_err, busy, runs_left}, 64'd0);

    // Ready held low for 5 cycles.
    start_seq(1, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ready_low_hold%0d", i), 64'(dut_start), 64'd1);
      if (i < 4) tick();
    end
    dut_ready = 1; tick(); dut_ready = 0;
    chk("ready_low_drop", {dut_start, busy}, 64'b01);
    dut_done = 1; tick(); dut_done = 0;
    chk("ready_low_seq_done", {seq_done, busy}, 64'b10);

    // Timeout of 8 cycles counted from WAIT entry.
    start_seq(1, 8);
    dut_ready = 1; tick(); dut_ready = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("timeout_wait%0d", k), {seq_done, timeout_err, busy}, 64'b001);
    end
    tick();
    chk("timeout_fire", {seq_done, timeout_err, busy}, 64'b110);
    tick();
    chk("timeout_sticky", {seq_done, timeout_err}, 64'b01);

    // Timeout disabled: waits indefinitely, then abort with no seq_done.
    n_sd = 0;
    start_seq(1, 0);
    chk("tmo0_terr_cleared", 64'(timeout_err), 64'd0);
    dut_ready = 1; tick(); dut_ready = 0;
    for (int k = 0; k < 40; k++) tick();
    chk("tmo0_still_busy", {busy, timeout_err}, 64'b10);
    abort = 1; tick(); abort = 0;
    chk("tmo0_abort", {busy, dut_start, seq_done}, 64'd0);
    chk("tmo0_no_seq_done", 64'(n_sd), 64'd0);

    // Done on the expiry cycle is a completion.
    start_seq(1, 3);
    dut_ready = 1; tick(); dut_ready = 0;
    tick(); tick();
    dut_done = 1; tick(); dut_done = 0;
    chk("done_at_expiry", {seq_done, timeout_err, busy}, 64'b100);

    // Abort during WAIT of run 2 of 4.
    n_sd = 0;
    start_seq(4, 0);
    dut_ready = 1; tick(); dut_ready = 0;
    mon_tvalid = 1; mon_tready = 1; mon_tlast = 1; tick();
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    dut_done = 1; tick(); dut_done = 0;
    dut_ready = 1; tick(); dut_ready = 0;
    mon_tvalid = 1; mon_tready = 1; tick();
    mon_tvalid = 0; mon_tready = 0;
    abort = 1; tick(); abort = 0;
    chk("abort_state", {busy, dut_start, seq_done}, 64'd0);
    chk("abort_runs_left", 64'(runs_left), 64'd2);
    chk("abort_counts_held", {pkt_count, beat_count}, {CNT_W'(1), 32'd2});
    tick();
    chk("abort_no_seq_done", 64'(n_sd), 64'd0);

    // pkt_count saturation at all-ones.
    start_seq(1, 0);
    dut_ready = 1; tick(); dut_ready = 0;
    mon_tvalid = 1; mon_tready = 1; mon_tlast = 1;
    for (int k = 0; k < 20; k++) tick();
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    chk("pkt_saturate", 64'(pkt_count), 64'hF);
    chk("beat_count_20", 64'(beat_count), 64'd20);
    abort = 1; tick(); abort = 0;

    // Reset mid-run clears everything at once; next go accepted at first edge.
    n_sd = 0;
    start_seq(2, 0);
    mon_tvalid = 1; mon_tready = 1; mon_tlast = 1; tick();
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    ap_rst_n = 0;
    #2;
    chk("midrun_reset", {dut_start, busy, seq_done, timeout_err, runs_left, pkt_count, beat_count},
        64'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1;
    start_seq(1, 0);
    chk("go_after_release", {dut_start, busy, runs_left}, {2'b11, CNT_W'(1)});
    chk("reset_no_seq_done", 64'(n_sd), 64'd0);
    dut_ready = 1; dut_done = 1; tick(); clear_inputs();
    chk("post_reset_done", {seq_done, busy}, 64'b10);

    // Randomized stimulus against the reference model.
    ap_rst_n = 0; tick(); ap_rst_n = 1;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      g = ($urandom_range(0, 3) == 0); a = ($urandom_range(0, 39) == 0);
      runs = int'($urandom_range(0, 3)); tmo = int'($urandom_range(0, 6));
      rdy = $urandom_range(0, 1) == 1; dn = ($urandom_range(0, 2) == 0);
      idl = ($urandom_range(0, 7) != 0);
      tv = $urandom_range(0, 1) == 1; tr = $urandom_range(0, 1) == 1;
      tl = $urandom_range(0, 1) == 1;
      go = g; abort = a; cfg_runs = CNT_W'(runs); cfg_timeout = TO_W'(tmo);
      dut_ready = rdy; dut_done = dn; dut_idle = idl;
      mon_tvalid = tv; mon_tready = tr; mon_tlast = tl;
      tick();
      model_step(g, a, runs, tmo, rdy, dn, idl, tv, tr, tl);
      rl_exp = CNT_W'(m_total - m_issued);
      chk($sformatf("rand_cycle%0d", cyc),
          {dut_start, busy, seq_done, timeout_err, runs_left, pkt_count, beat_count},
          {m_active && m_req, m_active, m_sd, m_terr, rl_exp, m_pkt, m_beat});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ap_run_sequencer.md
AP_RUN_SEQUENCER -- requirements
Module: ap_run_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the run-count and packet-count fields.
REQ-002 SHALL have parameter TO_W, default 16, width of the per-run timeout counter.
REQ-003 SHALL have port ap_clk  in  1  as its sole clock; all state SHALL change on the rising edge.
REQ-004 SHALL have port ap_rst_n  in  1  as the reset: asynchronous assert, active-low.
REQ-005 SHALL have port go  in  1  as a single-cycle request to begin a sequence.
REQ-006 SHALL have port abort  in  1  to terminate a sequence immediately.
REQ-007 SHALL have port cfg_runs  in  CNT_W  giving the number of kernel invocations, sampled with go.
REQ-008 SHALL have port cfg_timeout  in  TO_W  giving the cycles allowed per run, sampled with go; 0 disables the timeout.
REQ-009 SHALL have port dut_start  out  1  to drive the kernel ap_start.
REQ-010 SHALL have ports dut_ready, dut_done, dut_idle  in  1 each, from the kernel ap_ready/ap_done/ap_idle.
REQ-011 SHALL have ports mon_tvalid, mon_tready, mon_tlast  in  1 each, tapping the kernel output stream (passive).
REQ-012 SHALL have port busy  out  1, high while a sequence is in progress.
REQ-013 SHALL have port seq_done  out  1, a one-cycle pulse at sequence end.
REQ-014 SHALL have port timeout_err  out  1, a sticky flag for the last sequence.
REQ-015 SHALL have ports runs_left  out  CNT_W, pkt_count  out  CNT_W, beat_count  out  32.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT.
REQ-017 In IDLE, when go=1 and cfg_runs!=0, SHALL latch cfg_runs and cfg_timeout, clear pkt_count, beat_count and timeout_err, and enter START.
REQ-018 In IDLE, when go=1 and cfg_runs=0, SHALL pulse seq_done on the next cycle and stay in IDLE.
REQ-019 go SHALL be ignored outside IDLE.
REQ-020 dut_start SHALL be a registered output equal to 1 exactly while in START; it is high in the cycle after go is sampled.
REQ-021 In START, dut_start SHALL remain 1 until dut_ready=1 is sampled (ap_ctrl_hs hold rule); on that edge runs_left SHALL decrement and the FSM SHALL enter WAIT.
REQ-022 In START, when dut_ready and dut_done are both 1 in the same cycle, SHALL treat the run as complete and apply the WAIT completion rule directly.
REQ-023 In WAIT, a per-run timer SHALL count from 0 each cycle; on dut_done=1: runs_left=0 -> IDLE with seq_done pulse; otherwise -> START.
REQ-024 In WAIT, when cfg_timeout!=0 and the timer reaches cfg_timeout-1 without dut_done, SHALL set timeout_err, go to IDLE and pulse seq_done.
REQ-025 The timer SHALL reset to 0 on every entry to WAIT.
REQ-026 dut_done arriving in the same cycle as timer expiry SHALL count as completion, not timeout.
REQ-027 abort=1 in START or WAIT SHALL force IDLE on the next edge, with dut_start=0 and no seq_done pulse; pkt_count and beat_count SHALL be held.
REQ-028 abort SHALL take priority over go, dut_ready and dut_done.
REQ-029 busy SHALL be 1 in START and WAIT, 0 in IDLE.
REQ-030 While busy, beat_count SHALL increment on each mon_tvalid&mon_tready cycle, and pkt_count SHALL increment when mon_tlast is also 1.
REQ-031 Both counters SHALL saturate at all-ones.
REQ-032 dut_idle SHALL be used only to block leaving IDLE: go with dut_idle=0 SHALL be ignored.

Reset
REQ-033 On ap_rst_n=0, asynchronously: FSM=IDLE, dut_start=0, busy=0, seq_done=0, timeout_err=0, runs_left=0, pkt_count=0, beat_count=0, timer=0.
REQ-034 Reset asserted mid-sequence SHALL abandon it with no seq_done pulse.
REQ-035 The first go SHALL be accepted on the first rising edge after ap_rst_n is released.

Verification
REQ-036 Normal run: cfg_runs=3, kernel ready after 1 cycle and done after 10 cycles, each run emitting 4 beats with tlast on the 4th -> 3 dut_start assertions, seq_done once, pkt_count=3, beat_count=12, timeout_err=0.
REQ-037 Ready held low: dut_ready low for 5 cycles after dut_start -> dut_start stays high for all 5 cycles, then drops the cycle after dut_ready=1.
REQ-038 Same-cycle ready/done: dut_ready and dut_done both 1 with cfg_runs=1 -> IDLE and seq_done next cycle, runs_left=0.
REQ-039 Timeout: cfg_timeout=8, dut_done never asserted -> timeout_err=1 and seq_done 8 cycles after WAIT entry; with cfg_timeout=0 -> waits indefinitely.
REQ-040 Abort and reset: abort during WAIT of run 2 of 4 -> IDLE, no seq_done, counts held; ap_rst_n low mid-run -> all outputs 0 immediately; cfg_runs=0 -> seq_done only, no dut_start.
